// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one rs232out transmitter between NREQ message sources. Each source
// posts a left-aligned 36-bit word plus a digit count. Sources are granted
// round-robin. The word goes out as uppercase ASCII hex, MSB nibble first,
// optionally followed by CR LF. Every byte is presented with tx_we held high
// until rs232out accepts it (tx_busy low). A one-cycle GAP with tx_we low
// follows so the transmitter can raise busy before the next byte.
module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter bit CRLF = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [36*NREQ-1:0] req_word,
  input  logic [4*NREQ-1:0]  req_nibbles,
  output logic [NREQ-1:0]    ack,
  output logic [7:0]         tx_data,
  output logic               tx_we,
  input  logic               tx_busy,
  output logic               active,
  output logic [1:0]         cur_src
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // GAP is shared by every byte. It also covers the ack cycle right after a
  // grant. dest_q records where GAP hands over.
  typedef enum logic [2:0] {
    S_IDLE,
    S_HEX,
    S_CR,
    S_LF,
    S_GAP
  } state_t;

  state_t          state_q,   state_d;
  state_t          dest_q,    dest_d;
  logic [35:0]     word_q,    word_d;
  logic [3:0]      count_q,   count_d;
  logic [IW-1:0]   ptr_q,     ptr_d;
  logic [NREQ-1:0] ack_q,     ack_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_we_q,   tx_we_d;
  logic            active_q,  active_d;
  logic [1:0]      cur_src_q, cur_src_d;

  // Per-source views of the flattened request buses.
  logic [35:0]     word_arr [NREQ];
  logic [3:0]      nib_arr  [NREQ];

  // Round-robin scan result.
  logic            grant_vld;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic [3:0]      grant_cnt;

  // Increment modulo NREQ.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    if (v == IW'(NREQ - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Uppercase ASCII for one hex digit.
  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'd48 + {4'd0, d}) : (8'd55 + {4'd0, d});
  endfunction

  // Byte to present on entering a sending state from GAP.
  function automatic logic [7:0] char_for(input state_t s, input logic [35:0] w);
    case (s)
      S_HEX:   return hex_char(w[35:32]);
      S_CR:    return 8'd13;
      S_LF:    return 8'd10;
      default: return 8'd0;
    endcase
  endfunction

  // Split the packed request buses into per-source words and counts.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      word_arr[i] = req_word[36*i +: 36];
      nib_arr[i]  = req_nibbles[4*i +: 4];
    end
  end

  // Pick the first requesting source at or after ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    scan_idx  = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && req[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
    grant_cnt = (nib_arr[grant_idx] > 4'd9) ? 4'd9 : nib_arr[grant_idx];
  end

  // Next-state and next-output logic for the message sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves
    // one unassigned would infer a latch instead of plain logic.
    state_d   = state_q;
    dest_d    = dest_q;
    word_d    = word_q;
    count_d   = count_q;
    ptr_d     = ptr_q;
    ack_d     = '0;
    tx_data_d = tx_data_q;
    tx_we_d   = tx_we_q;
    cur_src_d = cur_src_q;

    case (state_q)
      S_IDLE: begin
        tx_we_d = 1'b0;
        if (grant_vld) begin
          ack_d[grant_idx] = 1'b1;
          word_d           = word_arr[grant_idx];
          count_d          = grant_cnt;
          cur_src_d        = 2'(grant_idx);
          ptr_d            = wrap_inc(grant_idx);
          // The ack cycle itself is spent in GAP. The first byte then
          // appears on the following cycle.
          if (grant_cnt != 4'd0) begin
            state_d = S_GAP;
            dest_d  = S_HEX;
          end else if (CRLF) begin
            state_d = S_GAP;
            dest_d  = S_CR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_HEX: begin
        if (tx_we_q && !tx_busy) begin
          tx_we_d = 1'b0;
          word_d  = {word_q[31:0], 4'h0};
          count_d = count_q - 4'd1;
          state_d = S_GAP;
          if (count_q > 4'd1) dest_d = S_HEX;
          else if (CRLF)      dest_d = S_CR;
          else                dest_d = S_IDLE;
        end
      end

      S_CR: begin
        if (tx_we_q && !tx_busy) begin
          tx_we_d = 1'b0;
          state_d = S_GAP;
          dest_d  = S_LF;
        end
      end

      S_LF: begin
        if (tx_we_q && !tx_busy) begin
          tx_we_d = 1'b0;
          state_d = S_GAP;
          dest_d  = S_IDLE;
        end
      end

      S_GAP: begin
        state_d = dest_q;
        if (dest_q != S_IDLE) begin
          tx_we_d   = 1'b1;
          tx_data_d = char_for(dest_q, word_q);
        end else begin
          tx_we_d = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_we_d = 1'b0;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  // State and registered outputs. Reset abandons any message in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      dest_q    <= S_IDLE;
      word_q    <= '0;
      count_q   <= '0;
      ptr_q     <= '0;
      ack_q     <= '0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
      active_q  <= 1'b0;
      cur_src_q <= '0;
    end else begin
      // NOTE: non-blocking assignments. All flops then update together from
      // pre-edge values, whatever order the statements are written in.
      state_q   <= state_d;
      dest_q    <= dest_d;
      word_q    <= word_d;
      count_q   <= count_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      tx_data_q <= tx_data_d;
      tx_we_q   <= tx_we_d;
      active_q  <= active_d;
      cur_src_q <= cur_src_d;
    end
  end

  assign ack     = ack_q;
  assign tx_data = tx_data_q;
  assign tx_we   = tx_we_q;
  assign active  = active_q;
  assign cur_src = cur_src_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter.
// u_dut (NREQ=2, CRLF=1) is compared every cycle against a byte-queue
// model of the message rules. u_nc (CRLF=0) covers the no-terminator cases.
module tb_uart_tx_arbiter;

  localparam int NREQ = 2;

  typedef struct packed {
    logic [35:0] word;
    logic [3:0]  nib;
  } msg_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [71:0] req_word = '0;
  logic [7:0]  req_nibbles = '0;
  logic [1:0]  ack;
  logic [7:0]  tx_data;
  logic        tx_we;
  logic        tx_busy = 1'b0;
  logic        active;
  logic [1:0]  cur_src;

  logic [1:0]  nc_req = '0;
  logic [71:0] nc_word = '0;
  logic [7:0]  nc_nib = '0;
  logic [1:0]  nc_ack;
  logic [7:0]  nc_tx_data;
  logic        nc_tx_we;
  logic        nc_busy = 1'b0;
  logic        nc_active;
  logic [1:0]  nc_cur_src;

  uart_tx_arbiter #(.NREQ(2), .CRLF(1'b1)) u_dut (
    .clock(clock), .reset(reset), .req(req), .req_word(req_word),
    .req_nibbles(req_nibbles), .ack(ack), .tx_data(tx_data), .tx_we(tx_we),
    .tx_busy(tx_busy), .active(active), .cur_src(cur_src)
  );

  uart_tx_arbiter #(.NREQ(2), .CRLF(1'b0)) u_nc (
    .clock(clock), .reset(reset), .req(nc_req), .req_word(nc_word),
    .req_nibbles(nc_nib), .ack(nc_ack), .tx_data(nc_tx_data), .tx_we(nc_tx_we),
    .tx_busy(nc_busy), .active(nc_active), .cur_src(nc_cur_src)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- stimulus: per-source message queues ----------------
  msg_t src0_q[$];
  msg_t src1_q[$];
  bit   armed0 = 0, armed1 = 0;
  bit   rand_gap = 0;
  bit   wd_req1 = 0;
  int   busy_mode = 0;  // 0 idle, 1 random, 2 forced high

  // A source raises req for its head message and holds it until ack.
  always @(negedge clock) begin
    if (ack[0] && src0_q.size() > 0) begin src0_q.delete(0); armed0 = 0; end
    if (ack[1] && src1_q.size() > 0) begin src1_q.delete(0); armed1 = 0; end
    if (!armed0 && src0_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) == 0)) armed0 = 1;
    if (!armed1 && src1_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) == 0)) armed1 = 1;
    req[0] = armed0;
    if (armed0) begin
      req_word[35:0]   = src0_q[0].word;
      req_nibbles[3:0] = src0_q[0].nib;
    end
    if (wd_req1) begin
      req[1]           = 1'b1;
      req_word[71:36]  = 36'h555555555;
      req_nibbles[7:4] = 4'd9;
    end else begin
      req[1] = armed1;
      if (armed1) begin
        req_word[71:36]  = src1_q[0].word;
        req_nibbles[7:4] = src1_q[0].nib;
      end
    end
    case (busy_mode)
      1:       tx_busy = ($urandom_range(0, 99) < 35);
      2:       tx_busy = 1'b1;
      default: tx_busy = 1'b0;
    endcase
  end

  // ---------------- behavioural model ----------------
  // A grant expands the message into its full byte list. One quiet cycle
  // follows the grant and each accepted byte. The head byte is presented
  // until the transmitter is not busy.
  int         m_phase = 0;  // 0 idle, 1 quiet, 2 presenting
  logic [7:0] m_bytes[$];
  logic [7:0] m_stream[$];
  logic [1:0] m_ack = '0;
  int         m_cur = 0;
  int         m_ptr = 0;
  int         m_grants = 0;

  task automatic model_step();
    int s, n, d;
    logic [35:0] w;
    bit done;
    m_ack = '0;
    if (m_phase == 0) begin
      done = 0;
      for (int k = 0; k < NREQ; k++) begin
        s = (m_ptr + k) % NREQ;
        if (!done && req[s]) begin
          done = 1;
          w = 36'(req_word >> (36 * s));
          n = int'(4'(req_nibbles >> (4 * s)));
          if (n > 9) n = 9;
          for (int j = 0; j < n; j++) begin
            d = int'(w >> (32 - 4 * j)) & 15;
            m_bytes.push_back(d < 10 ? 8'(48 + d) : 8'(55 + d));
          end
          m_bytes.push_back(8'd13);
          m_bytes.push_back(8'd10);
          m_ack[s] = 1'b1;
          m_cur    = s;
          m_ptr    = (s + 1) % NREQ;
          m_grants++;
          m_phase  = (m_bytes.size() > 0) ? 1 : 0;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = (m_bytes.size() > 0) ? 2 : 0;
    end else begin
      if (!tx_busy) begin
        m_stream.push_back(m_bytes.pop_front());
        m_phase = 1;
      end
    end
  endtask

  always @(posedge clock) if (reset) model_step();

  always @(negedge reset) begin
    m_phase = 0;
    m_bytes.delete();
    m_ack = '0;
    m_cur = 0;
    m_ptr = 0;
  end

  // ---------------- compare and record, half a cycle after the edge ----------------
  logic [7:0] d_stream[$];
  int         d_ack_src[$];
  int         ack_cnt0 = 0, ack_cnt1 = 0;
  logic [7:0] nc_stream[$];
  int         nc_ack0 = 0, nc_we_cnt = 0, nc_act_cnt = 0;

  always @(negedge clock) begin
    #1;
    if (reset) begin
      check("ack", ack, m_ack);
      check("tx_we", tx_we, m_phase == 2);
      check("active", active, m_phase != 0);
      check("cur_src", cur_src, m_cur);
      if (m_phase == 2 && m_bytes.size() > 0) check("tx_data", tx_data, m_bytes[0]);
    end
  end

  always @(negedge clock) begin
    #1;
    if (reset) begin
      if (tx_we && !tx_busy) d_stream.push_back(tx_data);
      if (ack[0]) begin ack_cnt0++; d_ack_src.push_back(0); end
      if (ack[1]) begin ack_cnt1++; d_ack_src.push_back(1); end
      if (nc_tx_we && !nc_busy) nc_stream.push_back(nc_tx_data);
      if (nc_tx_we) nc_we_cnt++;
      if (nc_active) nc_act_cnt++;
      if (nc_ack[0]) nc_ack0++;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [127:0] pack_s(input string s);
    logic [127:0] r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[119:0], s.getc(i)};
    return r;
  endfunction

  function automatic logic [127:0] pack_d();
    logic [127:0] r = '0;
    for (int i = 0; i < d_stream.size() && i < 16; i++) r = {r[119:0], d_stream[i]};
    return r;
  endfunction

  function automatic logic [127:0] pack_m();
    logic [127:0] r = '0;
    for (int i = 0; i < m_stream.size() && i < 16; i++) r = {r[119:0], m_stream[i]};
    return r;
  endfunction

  task automatic check_stream(input string name, input string exp);
    check({name, " length"}, d_stream.size(), exp.len());
    check({name, " bytes"}, pack_d(), pack_s(exp));
  endtask

  task automatic clear_logs();
    d_stream.delete();
    m_stream.delete();
    d_ack_src.delete();
    ack_cnt0 = 0;
    ack_cnt1 = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || active) && k < budget) begin
      tick();
      k++;
    end
    check({name, " finishes in budget"}, k < budget, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- directed and random sequences ----------------
  initial begin
    int k;
    int unsigned t0, t1;
    logic [7:0] order;
    int mism;

    // Reset values.
    tick();
    check("reset ack", ack, 2'b00);
    check("reset tx_we", tx_we, 1'b0);
    check("reset tx_data", tx_data, 8'd0);
    check("reset active", active, 1'b0);
    check("reset cur_src", cur_src, 2'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single source, 9 digits, latency from grant back to idle.
    clear_logs();
    src0_q.push_back('{word: 36'h1A2B3C4D5, nib: 4'd9});
    k = 0;
    while (!ack[0] && k < 20) begin tick(); k++; end
    check("single ack seen", ack[0], 1'b1);
    t0 = cyc;
    k = 0;
    while (active && k < 100) begin tick(); k++; end
    t1 = cyc;
    check("single latency", t1 - t0, 23);
    check("single ack count", ack_cnt0, 1);
    check_stream("single", "1A2B3C4D5\015\012");
    check("model stream single", pack_m(), pack_s("1A2B3C4D5\015\012"));

    // Round-robin with both sources requesting continuously.
    do_reset();
    clear_logs();
    src0_q.push_back('{word: 36'hF00000000, nib: 4'd1});
    src0_q.push_back('{word: 36'hF00000000, nib: 4'd1});
    src1_q.push_back('{word: 36'h900000000, nib: 4'd1});
    src1_q.push_back('{word: 36'h900000000, nib: 4'd1});
    wait_done("rr", 200);
    check_stream("rr", "F\015\0129\015\012F\015\0129\015\012");
    order = '0;
    foreach (d_ack_src[i]) order = {order[5:0], 2'(d_ack_src[i])};
    check("rr ack order", order, 8'b00_01_00_01);

    // Backpressure on the second digit.
    clear_logs();
    src0_q.push_back('{word: 36'hABC000000, nib: 4'd3});
    k = 0;
    while (!(tx_we && tx_data == 8'd66) && k < 40) begin tick(); k++; end
    check("bp second digit presented", k < 40, 1'b1);
    busy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp hold", {tx_we, tx_data}, {1'b1, 8'd66});
    end
    busy_mode = 0;
    wait_done("bp", 100);
    check_stream("bp", "ABC\015\012");

    // Count 0 sends only the terminator; count 15 is clamped to 9 digits.
    clear_logs();
    src0_q.push_back('{word: 36'h123456789, nib: 4'd0});
    wait_done("count0", 50);
    check_stream("count0", "\015\012");
    clear_logs();
    src0_q.push_back('{word: 36'h123456789, nib: 4'd15});
    wait_done("count15", 100);
    check_stream("count15", "123456789\015\012");

    // CRLF=0 instance: count 0 gives only an ack, count 2 gives two bytes.
    nc_stream.delete();
    nc_ack0 = 0;
    nc_we_cnt = 0;
    nc_act_cnt = 0;
    nc_word[35:0] = 36'h123456789;
    nc_nib[3:0] = 4'd0;
    nc_req = 2'b01;
    k = 0;
    while (!nc_ack[0] && k < 10) begin tick(); k++; end
    nc_req = 2'b00;
    repeat (10) tick();
    check("nc count0 acks", nc_ack0, 1);
    check("nc count0 tx_we cycles", nc_we_cnt, 0);
    check("nc count0 active cycles", nc_act_cnt, 0);
    nc_ack0 = 0;
    nc_word[35:0] = 36'hAB0000000;
    nc_nib[3:0] = 4'd2;
    nc_req = 2'b01;
    k = 0;
    while (!nc_ack[0] && k < 10) begin tick(); k++; end
    nc_req = 2'b00;
    k = 0;
    while (nc_active && k < 50) begin tick(); k++; end
    check("nc ab acks", nc_ack0, 1);
    check("nc ab length", nc_stream.size(), 2);
    if (nc_stream.size() == 2) check("nc ab bytes", {nc_stream[0], nc_stream[1]}, 16'h4142);

    // Reset while the 4th character is presented.
    clear_logs();
    src0_q.push_back('{word: 36'h1A2B3C4D5, nib: 4'd9});
    k = 0;
    while (!(d_stream.size() == 3 && tx_we) && k < 40) begin tick(); k++; end
    check("rst 4th char presented", k < 40, 1'b1);
    reset = 1'b0;
    #1;
    check("rst tx_we drops", tx_we, 1'b0);
    check("rst active drops", active, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    clear_logs();
    src1_q.push_back('{word: 36'h7E0000000, nib: 4'd2});
    wait_done("rst fresh", 100);
    check("rst first grant count", d_ack_src.size(), 1);
    if (d_ack_src.size() > 0) check("rst first grant src", d_ack_src[0], 1);
    check_stream("rst fresh", "7E\015\012");

    // Withdrawal: req[1] high for one cycle while source 0 is active.
    clear_logs();
    src0_q.push_back('{word: 36'h1A2B3C4D5, nib: 4'd9});
    k = 0;
    while (!active && k < 20) begin tick(); k++; end
    repeat (4) tick();
    wd_req1 = 1;
    tick();
    wd_req1 = 0;
    wait_done("withdraw", 100);
    check("withdraw no ack1", ack_cnt1, 0);
    check_stream("withdraw", "1A2B3C4D5\015\012");

    // Random traffic and random backpressure against the model.
    clear_logs();
    m_grants = 0;
    rand_gap = 1;
    busy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      src0_q.push_back('{word: 36'({$urandom(), $urandom()}), nib: 4'($urandom_range(0, 15))});
      src1_q.push_back('{word: 36'({$urandom(), $urandom()}), nib: 4'($urandom_range(0, 15))});
    end
    wait_done("random", 20000);
    busy_mode = 0;
    rand_gap = 0;
    check("random acks", ack_cnt0 + ack_cnt1, 80);
    check("random model grants", m_grants, 80);
    check("random stream length", d_stream.size(), m_stream.size());
    mism = 0;
    for (int i = 0; i < d_stream.size() && i < m_stream.size(); i++)
      if (d_stream[i] !== m_stream[i]) mism++;
    check("random stream bytes", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single rs232out transmitter between NREQ message sources, for example the finish-result dump, GC-event marker and io-write trace.
- Each source posts a left-aligned 36-bit word and a digit count. The arbiter grants sources round-robin and sends the word as uppercase ASCII hex, MSB nibble first.
- Each message is optionally followed by CR LF.
- Sits in the board toplevel between the Reduceron core taps and rs232out.

Parameters:
NREQ, 2, number of requesters (2..4)
CRLF, 1, 1 = append CR (13), LF (10) after every message; 0 = no terminator

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req  in  NREQ  per-source request level
req_word  in  36*NREQ  source i word in bits [36*i+35:36*i]; first digit is bits [35:32]
req_nibbles  in  4*NREQ  source i digit count in bits [4*i+3:4*i]; valid range 0..9
ack  out  NREQ  one-cycle pulse: source i's word has been latched
tx_data  out  8  byte to rs232out transmit_data
tx_we  out  1  byte valid to rs232out we
tx_busy  in  1  rs232out busy
active  out  1  a message is in progress (any state except IDLE)
cur_src  out  2  index of the source being sent; holds its last value when idle

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; ack=0, tx_we=0, tx_data=0, active=0, cur_src=0.
  - Round-robin pointer ptr=0; word and count registers cleared.
- State IDLE:
  - If no req bit is set, remain in IDLE.
  - Otherwise, at the edge, select the first set req bit scanning ptr, ptr+1, ..., wrapping modulo NREQ. Call it index g.
  - At that edge: latch req_word[g] and the count; ack[g]=1 for exactly one cycle; cur_src=g; ptr=(g+1) mod NREQ.
  - Count >9 is clamped to 9.
  - Next state: HEX if count>0; else CR if CRLF=1; else IDLE.
  - With count 0 and CRLF=0 the message is empty: ack still pulses and nothing is sent.
- Requester rule: hold req, word and count stable until ack. The block may sample them only on the grant edge.
- Deasserting req before ack withdraws the request. No ack is then produced.
- State HEX:
  - Present a character: tx_data = d<10 ? d+48 : d+55, where d = word[35:32]; tx_we=1.
  - The byte is accepted on the first edge where tx_we=1 and tx_busy=0.
  - On acceptance: word <<= 4, count -= 1, tx_we=0 for exactly one GAP cycle so rs232out can raise busy.
  - After GAP: re-present from HEX if count>0; else CR (CRLF=1); else IDLE.
- State CR: present 13 with the same accept and GAP rule, then go to LF.
- State LF: present 10 with the same accept and GAP rule, then go to IDLE.
- Output timing:
  - tx_data and tx_we are registered. tx_data is stable throughout tx_we=1.
  - The first character is presented the cycle after the ack cycle.
  - Back-to-back messages: IDLE re-arbitrates on the cycle after the final GAP.
- Latency with tx_busy=0 throughout:
  - Each byte costs 2 cycles (present + GAP).
  - An N-digit message with CRLF takes 1 + 2(N+2) cycles from the grant edge back to IDLE.
- tx_busy high stalls the current state indefinitely. tx_data and word are held; no ack pulses during a stall.
- A req rising while a message is active waits; arbitration happens only in IDLE.
- Reset mid-message:
  - Returns to IDLE immediately; tx_we drops asynchronously.
  - The partial message is abandoned with no terminator. ptr returns to 0.
- active=1 in HEX, CR, LF and GAP; active=0 in IDLE.

Test Plan:
- Single source: NREQ=2, CRLF=1, req[0] with word 36'h1A2B3C4D5 and count 9, tx_busy=0.
  - ack[0] pulses once.
  - Bytes "1A2B3C4D5" then 13, 10 (ASCII 49,65,50,66,51,67,52,68,53,13,10).
  - tx_we pulses alternate with GAP cycles; back to IDLE 23 cycles after the grant.
- Round-robin: both req held continuously.
  - Source 0 word 36'hF0000_0000, count 1; source 1 word 36'h90000_0000, count 1.
  - Output sequence is "F\r\n9\r\nF\r\n9\r\n".
  - ack alternates 0,1,0,1; cur_src tracks it.
- Backpressure: hold tx_busy=1 for 20 cycles while the second digit of word 36'hABC00_0000 (count 3) is presented.
  - tx_data=66 and tx_we=1 held throughout; no duplicate byte.
  - Final stream is "ABC\r\n".
- Edge counts:
  - Count 0 with CRLF=1 sends only 13, 10.
  - Count 0 with CRLF=0 sends nothing but ack pulses.
  - Count 15 is clamped to 9 digits.
- Reset mid-message: assert reset during the 4th character.
  - tx_we=0 and active=0 at once.
  - After release, a fresh req[1] is granted first (ptr=0 scan finds 1) and is sent from its first digit.
- Withdrawal: req[1] pulses for 1 cycle while source 0 is active.
  - No ack[1] is produced, and no source-1 bytes are sent.
